// File: rtl/csr_access_unit_if.sv
// Request/response bus between a pipeline stage issuing Zicsr operations
// and the CSR access unit that sequences them against the CSR file.
interface csr_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [63:0] req_src;
    logic [4:0]  req_zimm;
    logic        req_rs1_zero;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_illegal;

    // Pipeline side issuing CSR instructions and consuming the old value.
    modport master (
        output req_valid, req_op, req_addr, req_src, req_zimm, req_rs1_zero,
        output resp_ready,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_illegal
    );

    // CSR access unit side.
    modport slave (
        input  req_valid, req_op, req_addr, req_src, req_zimm, req_rs1_zero,
        input  resp_ready,
        output req_ready,
        output resp_valid, resp_rdata, resp_illegal
    );
endinterface

// File: rtl/csr_access_unit.sv
// Sequences one Zicsr read-modify-write against a CSR file with a
// combinational read port and a single-cycle write port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; the only state that accepts one
// READ  | csr_ren pulse, old value captured at the closing edge
// WRITE | csr_wen pulse with the computed new value
// RESP  | response held until resp_ready; carries old value / illegal
module csr_access_unit (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    csr_access_unit_if.slave        bus,
    output logic                    csr_ren,
    output logic [11:0]             csr_raddr,
    input  logic [63:0]             csr_rdata,
    output logic                    csr_wen,
    output logic [11:0]             csr_waddr,
    output logic [63:0]             csr_wdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [2:0]  op_q;
    logic [11:0] addr_q;
    logic [63:0] operand_q;
    logic [63:0] old_q;
    logic [63:0] new_q;
    logic        suppress_q;
    logic        illegal_q;

    logic        accept;
    logic        op_illegal;
    logic        req_suppress;
    logic [63:0] req_operand;
    logic        read_only;
    logic [63:0] new_val;

    // Acceptance is blocked by a concurrent flush and while reset is held.
    assign bus.req_ready = (state == IDLE) && !flush && !reset;
    assign accept        = bus.req_valid && bus.req_ready;

    // funct3 000 and 100 have no CSR meaning.
    assign op_illegal  = (bus.req_op[1:0] == 2'b00);
    assign req_operand = bus.req_op[2] ? {59'd0, bus.req_zimm} : bus.req_src;

    // Set/clear with a zero source never writes; plain write always does.
    assign req_suppress = !op_illegal && (bus.req_op[1:0] != 2'b01) &&
                          (bus.req_op[2] ? (bus.req_zimm == 5'd0) : bus.req_rs1_zero);

    assign read_only = (addr_q[11:10] == 2'b11);

    // New value computed from the live read data during READ.
    always_comb begin
        new_val = csr_rdata;
        case (op_q[1:0])
            2'b01:   new_val = operand_q;
            2'b10:   new_val = csr_rdata | operand_q;
            2'b11:   new_val = csr_rdata & ~operand_q;
            default: new_val = csr_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; flush abandons whatever is in flight.
    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_n = op_illegal ? RESP : READ;
                READ:    state_n = (!suppress_q && !read_only) ? WRITE : RESP;
                WRITE:   state_n = RESP;
                RESP:    if (bus.resp_ready) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Request latch and old/new value capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= '0;
            addr_q     <= '0;
            operand_q  <= '0;
            old_q      <= '0;
            new_q      <= '0;
            suppress_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (accept) begin
            op_q       <= bus.req_op;
            addr_q     <= bus.req_addr;
            operand_q  <= req_operand;
            suppress_q <= req_suppress;
            illegal_q  <= op_illegal;
            old_q      <= '0;
        end else if (state == READ) begin
            old_q      <= csr_rdata;
            new_q      <= new_val;
            // Writing a read-only CSR is illegal; merely reading it is not.
            illegal_q  <= read_only && !suppress_q;
        end
    end

    // Strobes and response; everything quiet while reset is asserted.
    always_comb begin
        csr_ren          = 1'b0;
        csr_wen          = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.resp_rdata   = '0;
        bus.resp_illegal = 1'b0;
        if (!reset) begin
            csr_ren = (state == READ);
            csr_wen = (state == WRITE) && !flush;
            if (state == RESP) begin
                bus.resp_valid   = !flush;
                bus.resp_rdata   = old_q;
                bus.resp_illegal = illegal_q;
            end
        end
    end

    assign csr_raddr = addr_q;
    assign csr_waddr = addr_q;
    assign csr_wdata = new_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: a CSR file array serves the DUT, a reference
// model computes expected responses/writes from the instruction semantics,
// and a monitor thread checks them as the DUT presents them.
module tb_csr_access_unit;

    typedef struct {
        logic [63:0] rdata;
        logic        ill;
    } resp_t;

    typedef struct {
        logic [11:0] addr;
        logic [63:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        csr_ren;
    logic [11:0] csr_raddr;
    logic [63:0] csr_rdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;

    logic        mem_init;
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [63:0] pl_data;

    logic [63:0] csr_mem [4096];
    logic [63:0] ref_mem [4096];

    resp_t exp_resp [$];
    wr_t   exp_wr   [$];

    int errors;
    int checks;

    csr_access_unit_if bus();

    csr_access_unit dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .csr_ren   (csr_ren),
        .csr_raddr (csr_raddr),
        .csr_rdata (csr_rdata),
        .csr_wen   (csr_wen),
        .csr_waddr (csr_waddr),
        .csr_wdata (csr_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_val(input int i);
        return {32'(i) * 32'h9E37_79B1, 32'h0000_A000 | 32'(i)};
    endfunction

    assign csr_rdata = csr_mem[csr_raddr];

    // CSR file seen by the DUT.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= init_val(i);
        end else if (pl_en) begin
            csr_mem[pl_addr] <= pl_data;
        end else if (csr_wen) begin
            csr_mem[csr_waddr] <= csr_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level semantics of CSRRW/RS/RC and immediate forms.
    task automatic model(input logic [2:0] op, input logic [11:0] addr,
                         input logic [63:0] src, input logic [4:0] zimm,
                         input logic rs1z, output resp_t er, output logic do_wr,
                         output wr_t ew, output int lat, output int ren);
        logic [63:0] operand;
        logic [63:0] old;
        logic        suppress;
        operand = op[2] ? {59'd0, zimm} : src;
        do_wr   = 1'b0;
        ew.addr = addr;
        ew.data = '0;
        if (op[1:0] == 2'b00) begin
            er.rdata = '0; er.ill = 1'b1; lat = 1; ren = 0;
            return;
        end
        old      = ref_mem[addr];
        suppress = (op[1:0] != 2'b01) && (op[2] ? (zimm == 5'd0) : rs1z);
        er.rdata = old;
        ren      = 1;
        if (addr[11:10] == 2'b11 && !suppress) begin
            er.ill = 1'b1; lat = 2;
        end else if (suppress) begin
            er.ill = 1'b0; lat = 2;
        end else begin
            er.ill = 1'b0; lat = 3; do_wr = 1'b1;
            case (op[1:0])
                2'b01:   ew.data = operand;
                2'b10:   ew.data = old | operand;
                default: ew.data = old & ~operand;
            endcase
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [63:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [11:0] addr,
                             input logic [63:0] src, input logic [4:0] zimm, input logic rs1z);
        bus.req_op = op; bus.req_addr = addr; bus.req_src = src;
        bus.req_zimm = zimm; bus.req_rs1_zero = rs1z; bus.req_valid = 1'b1;
    endtask

    task automatic do_req(input logic [2:0] op, input logic [11:0] addr,
                          input logic [63:0] src, input logic [4:0] zimm,
                          input logic rs1z, input int stall);
        resp_t er; wr_t ew; logic do_wr;
        int exp_lat, exp_ren, lat, ren_cnt, waits;
        logic got, seen;
        logic [64:0] snap;
        model(op, addr, src, zimm, rs1z, er, do_wr, ew, exp_lat, exp_ren);
        bus.resp_ready = (stall == 0);
        drive_req(op, addr, src, zimm, rs1z);
        got = 1'b0; waits = 0;
        while (!got && waits < 20) begin
            @(negedge clk);
            if (bus.req_ready) got = 1'b1; else waits++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("accept_wait", 64'(waits), 64'd0);
        if (!got) begin
            bus.resp_ready = 1'b1;
            return;
        end
        exp_resp.push_back(er);
        if (do_wr) begin
            exp_wr.push_back(ew);
            ref_mem[addr] = ew.data;
        end
        lat = 0; ren_cnt = 0; seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (csr_ren) ren_cnt++;
            if (bus.resp_valid) seen = 1'b1;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("ren_count", 64'(ren_cnt), 64'(exp_ren));
        if (!seen) begin
            bus.resp_ready = 1'b1;
            return;
        end
        snap = {bus.resp_illegal, bus.resp_rdata};
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("stall_hold", {61'd0, bus.resp_valid, bus.req_ready,
                               ({bus.resp_illegal, bus.resp_rdata} == snap)}, 64'b101);
        end
        if (stall > 0) begin
            @(posedge clk); #1;
            bus.resp_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_monitor();
        resp_t er;
        wr_t   ew;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (csr_wen) begin
                    if (exp_wr.size() == 0) begin
                        chk("wen_unexpected", {63'd0, csr_wen}, 64'd0);
                    end else begin
                        ew = exp_wr.pop_front();
                        chk("wr_addr", 64'(csr_waddr), 64'(ew.addr));
                        chk("wr_data", csr_wdata, ew.data);
                    end
                end
                if (bus.resp_valid && bus.resp_ready) begin
                    if (exp_resp.size() == 0) begin
                        chk("resp_unexpected", {63'd0, bus.resp_valid}, 64'd0);
                    end else begin
                        er = exp_resp.pop_front();
                        chk("resp_rdata", bus.resp_rdata, er.rdata);
                        chk("resp_illegal", {63'd0, bus.resp_illegal}, {63'd0, er.ill});
                    end
                end
            end
        end
    endtask

    task automatic run_stimulus();
        logic [11:0] pool [8];
        logic [2:0]  op;
        logic [4:0]  zimm;
        pool = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h344, 12'hF14, 12'hC00, 12'hB00};

        reset = 1'b1; flush = 1'b0; mem_init = 1'b1; pl_en = 1'b0;
        pl_addr = '0; pl_data = '0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_src = '0;
        bus.req_zimm = '0; bus.req_rs1_zero = 1'b0; bus.resp_ready = 1'b1;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        @(posedge clk); #1;
        mem_init = 1'b0;
        bus.req_valid = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {59'd0, bus.req_ready, bus.resp_valid, csr_ren, csr_wen,
                            bus.resp_illegal}, 64'd0);
        chk("rst_rdata", bus.resp_rdata, 64'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_release_quiet", {60'd0, bus.resp_valid, csr_ren, csr_wen,
                                  bus.resp_illegal}, 64'd0);
        @(posedge clk); #1;

        // Directed cases: mtvec write, suppressed set, immediate clear/set.
        preload(12'h305, 64'h100);
        do_req(3'b001, 12'h305, 64'h8000_0000, 5'd0, 1'b0, 0);
        preload(12'h300, 64'h1888);
        do_req(3'b010, 12'h300, 64'hFFFF, 5'd0, 1'b1, 0);
        preload(12'h344, 64'h88);
        do_req(3'b111, 12'h344, 64'd0, 5'h08, 1'b0, 0);
        do_req(3'b110, 12'h344, 64'd0, 5'h03, 1'b0, 0);
        do_req(3'b010, 12'h344, 64'd0, 5'd0, 1'b1, 0);
        // Read-only write attempt, illegal funct3, read-only plain read.
        do_req(3'b001, 12'hF14, 64'h1234, 5'd0, 1'b0, 0);
        do_req(3'b100, 12'h305, 64'h1234, 5'd7, 1'b0, 0);
        do_req(3'b000, 12'h305, 64'h1234, 5'd7, 1'b0, 1);
        do_req(3'b010, 12'hF14, 64'd0, 5'd0, 1'b1, 0);
        // Response back-pressure followed immediately by another request.
        do_req(3'b011, 12'h305, 64'hF000_0000_0000_0100, 5'd0, 1'b0, 5);
        do_req(3'b010, 12'h305, 64'd0, 5'd0, 1'b1, 0);

        // Flush in IDLE blocks acceptance.
        drive_req(3'b001, 12'h340, 64'hDEAD, 5'd0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_ready", {63'd0, bus.req_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; bus.req_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle_noaccept", {62'd0, bus.resp_valid, csr_ren}, 64'd0);
        @(posedge clk); #1;

        // Flush during WRITE: no write, no response, back to IDLE.
        drive_req(3'b001, 12'h341, 64'hBAD0_BAD0, 5'd0, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_write", {62'd0, csr_wen, bus.resp_valid}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_to_idle", {61'd0, bus.req_ready, bus.resp_valid, csr_wen}, 64'b100);
        @(posedge clk); #1;
        do_req(3'b010, 12'h341, 64'd0, 5'd0, 1'b1, 0);

        // Reset while in READ abandons the access.
        drive_req(3'b011, 12'h300, 64'h1, 5'd0, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_read", {59'd0, bus.req_ready, bus.resp_valid, csr_ren, csr_wen,
                           bus.resp_illegal}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_release", {60'd0, bus.req_ready, bus.resp_valid, csr_ren, csr_wen},
            64'b1000);
        @(posedge clk); #1;
        do_req(3'b010, 12'h300, 64'd0, 5'd0, 1'b1, 0);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            op   = 3'($urandom_range(0, 7));
            zimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            do_req(op, pool[$urandom_range(0, 7)], {$urandom, $urandom}, zimm,
                   1'($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("resp_left", 64'(exp_resp.size()), 64'd0);
        chk("wr_left", 64'(exp_wr.size()), 64'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        fork
            run_monitor();
            run_stimulus();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
